imm_splitter: RTL and testbench

Inverse of the immediate sign-extension path. Accepts a 32-bit signed constant and emits the shortest sequence of 15-bit immediate beats from which the decode side rebuilds the value exactly. The top beat is sign-extended; each lower beat is appended as 15 raw bits. Sits in the instruction-builder/loader path, feeding the constant-materialisation sequence (1, 2 or 3 immediate-carrying instructions).

---
 rtl/imm_pkg.sv | 21 ++
 rtl/imm_fit_calc.sv | 28 ++
 rtl/imm_splitter.sv | 107 ++++++++++
 tb/tb_imm_splitter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants, types and helpers for splitting 32-bit constants into 15-bit immediate beats.
package imm_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IMM_W  = 15;
    localparam int unsigned NB     = 3;
    localparam int unsigned EXT_W  = NB * IMM_W;

    typedef logic [1:0] beat_cnt_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Sign-extend a constant so every beat slice can be taken from a fixed-width word.
    function automatic logic [EXT_W-1:0] sext_to_ext(input logic [DATA_W-1:0] data);
        return {{(EXT_W - DATA_W){data[DATA_W-1]}}, data};
    endfunction

endpackage

// File: rtl/imm_fit_calc.sv
// Minimum number of 15-bit beats needed to rebuild a signed 32-bit constant.
module imm_fit_calc
    import imm_pkg::*;
(
    input  logic [DATA_W-1:0] in_data,
    output beat_cnt_t         beat_count_c
);

    localparam int unsigned ONE_LSB = IMM_W - 1;
    localparam int unsigned TWO_LSB = 2 * IMM_W - 1;

    logic fits_one_c;
    logic fits_two_c;

    // A value fits n beats when every bit above the top beat's sign bit copies it.
    assign fits_one_c = (&in_data[DATA_W-1:ONE_LSB]) | ~(|in_data[DATA_W-1:ONE_LSB]);
    assign fits_two_c = (&in_data[DATA_W-1:TWO_LSB]) | ~(|in_data[DATA_W-1:TWO_LSB]);

    always_comb begin
        beat_count_c = 2'd3;
        if (fits_one_c) begin
            beat_count_c = 2'd1;
        end else if (fits_two_c) begin
            beat_count_c = 2'd2;
        end
    end

endmodule

// File: rtl/imm_splitter.sv
// Splits a signed 32-bit constant into the shortest top-first sequence of 15-bit immediate beats.
module imm_splitter
    import imm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMM_W-1:0]  out_imm,
    output logic              out_first,
    output logic              out_last,
    output logic [1:0]        out_count,
    output logic [1:0]        out_idx
);

    state_t             state_q, state_d;
    logic [EXT_W-1:0]   held_q, held_d;
    beat_cnt_t          count_q, count_d;
    beat_cnt_t          idx_q, idx_d;
    logic [IMM_W-1:0]   imm_q, imm_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    beat_cnt_t          fit_count_c;
    beat_cnt_t          sel_c;
    logic               take_c;

    imm_fit_calc u_fit (
        .in_data      (in_data),
        .beat_count_c (fit_count_c)
    );

    // A new constant may enter while idle or on the handshake of the final beat.
    assign out_valid = (state_q == SEND);
    assign in_ready  = rst_n & ((state_q == IDLE) | (out_valid & out_ready & last_q));
    assign take_c    = in_valid & in_ready;

    assign out_imm   = imm_q;
    assign out_first = first_q;
    assign out_last  = last_q;
    assign out_count = count_q;
    assign out_idx   = idx_q;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        count_d = count_q;
        idx_d   = idx_q;
        imm_d   = '0;
        first_d = 1'b0;
        last_d  = 1'b0;
        sel_c   = '0;

        if ((state_q == SEND) && out_ready) begin
            if (last_q) begin
                state_d = IDLE;
                count_d = '0;
                idx_d   = '0;
            end else begin
                idx_d = beat_cnt_t'(idx_q + 2'd1);
            end
        end

        if (take_c) begin
            held_d  = sext_to_ext(in_data);
            count_d = fit_count_c;
            idx_d   = '0;
            state_d = SEND;
        end

        // Beat i of K is slice K-1-i of the extended value; outputs follow the next state.
        if (state_d == SEND) begin
            sel_c = beat_cnt_t'(count_d - idx_d - 2'd1);
            case (sel_c)
                2'd0:    imm_d = held_d[IMM_W-1:0];
                2'd1:    imm_d = held_d[2*IMM_W-1:IMM_W];
                2'd2:    imm_d = held_d[3*IMM_W-1:2*IMM_W];
                default: imm_d = '0;
            endcase
            first_d = (idx_d == 2'd0);
            last_d  = (idx_d == beat_cnt_t'(count_d - 2'd1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            held_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            imm_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            imm_q   <= imm_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_imm_splitter.sv
// Self-checking bench for imm_splitter: directed cases plus random constants against an arithmetic model.
module tb_imm_splitter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_imm;
    logic        out_first;
    logic        out_last;
    logic [1:0]  out_count;
    logic [1:0]  out_idx;

    int          n_checks;
    int          n_fail;
    logic [14:0] obs [3];
    int          obs_n;

    imm_splitter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_first (out_first),
        .out_last  (out_last),
        .out_count (out_count),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Smallest k such that the value lies in the signed range of 15*k bits.
    function automatic int model_k(input logic [31:0] v);
        longint s;
        longint lim;
        s = longint'(signed'(v));
        for (int k = 1; k <= 3; k++) begin
            lim = longint'(1) <<< (15 * k - 1);
            if (s >= -lim && s < lim) return k;
        end
        return 3;
    endfunction

    function automatic logic [14:0] model_beat(input logic [31:0] v, input int k, input int i);
        longint s;
        longint b;
        s = longint'(signed'(v));
        b = (s >>> (15 * (k - 1 - i))) & 64'h7FFF;
        return b[14:0];
    endfunction

    task automatic check_beat(input logic [31:0] v, input int k, input int i);
        check("valid", out_valid, 1);
        check("imm",   out_imm,   model_beat(v, k, i));
        check("first", out_first, (i == 0));
        check("last",  out_last,  (i == k - 1));
        check("count", out_count, k);
        check("idx",   out_idx,   i);
    endtask

    // One transaction from idle; optionally stall before beat stall_idx for stall_n cycles.
    task automatic run_txn(input logic [31:0] v, input int stall_idx, input int stall_n);
        int     k;
        longint acc;
        k = model_k(v);
        in_data   = v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom();
        #1;
        for (int i = 0; i < k; i++) begin
            if (i == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    #1;
                    check_beat(v, k, i);
                    check("stall_ready", in_ready, 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                #1;
            end
            check_beat(v, k, i);
            check("busy_ready", in_ready, (i == k - 1));
            obs[i] = out_imm;
            @(posedge clk); #1;
        end
        obs_n = k;
        check("idle_after", out_valid, 0);
        acc = longint'(signed'(obs[0]));
        for (int i = 1; i < k; i++) acc = (acc <<< 15) | longint'(obs[i]);
        check("rebuild", acc[31:0], v);
    endtask

    logic [31:0] edges [12];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        obs_n     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        edges = '{32'h00003FFF, 32'hFFFFC000, 32'h00004000, 32'hFFFFBFFF,
                  32'h1FFFFFFF, 32'hE0000000, 32'h20000000, 32'hDFFFFFFF,
                  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};

        #2;
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_imm",   out_imm, 0);
        check("rst_first", out_first, 0);
        check("rst_last",  out_last, 0);
        check("rst_count", out_count, 0);
        check("rst_idx",   out_idx, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 1);

        run_txn(32'h00001234, -1, 0);
        check("d1234_n", obs_n, 1);
        check("d1234_b0", obs[0], 15'h1234);

        run_txn(32'hFFFFC000, -1, 0);
        check("dneg_n", obs_n, 1);
        check("dneg_b0", obs[0], 15'h4000);

        run_txn(32'h00004000, -1, 0);
        check("dpos_n", obs_n, 2);
        check("dpos_b0", obs[0], 15'h0000);
        check("dpos_b1", obs[1], 15'h4000);

        run_txn(32'h7FFFFFFF, -1, 0);
        check("dmax_n", obs_n, 3);
        check("dmax_b0", obs[0], 15'h0001);
        check("dmax_b1", obs[1], 15'h7FFF);
        check("dmax_b2", obs[2], 15'h7FFF);

        run_txn(32'h80000000, -1, 0);
        check("dmin_n", obs_n, 3);
        check("dmin_b0", obs[0], 15'h7FFE);
        check("dmin_b1", obs[1], 15'h0000);
        check("dmin_b2", obs[2], 15'h0000);

        run_txn(32'h7FFFFFFF, 1, 4);
        check("dstall_b1", obs[1], 15'h7FFF);

        // Back-to-back: second constant taken on the last-beat handshake of the first.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h00004000;
        @(posedge clk); #1;
        in_data = 32'h00000005;
        #1;
        check("b2b_imm0",   out_imm, 15'h0000);
        check("b2b_ready0", in_ready, 0);
        @(posedge clk); #1;
        check("b2b_imm1",   out_imm, 15'h4000);
        check("b2b_last1",  out_last, 1);
        check("b2b_ready1", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        check("b2b_valid2", out_valid, 1);
        check("b2b_imm2",   out_imm, 15'h0005);
        check("b2b_first2", out_first, 1);
        check("b2b_count2", out_count, 1);
        @(posedge clk); #1;
        check("b2b_idle", out_valid, 0);

        // Asynchronous reset in the middle of a three-beat transaction.
        in_valid = 1'b1;
        in_data  = 32'h7FFFFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_idx", out_idx, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_ready", in_ready, 0);
        check("mrst_idx",   out_idx, 0);
        check("mrst_count", out_count, 0);
        check("mrst_imm",   out_imm, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("mrst_ready_after", in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            check("mrst_no_stale", out_valid, 0);
            @(posedge clk); #1;
        end

        for (int n = 0; n < 10000; n++) begin
            logic [31:0] r;
            logic [31:0] v;
            r = $urandom();
            case ($urandom_range(0, 3))
                0:       v = r;
                1:       v = {{17{r[14]}}, r[14:0]};
                2:       v = {{2{r[29]}}, r[29:0]};
                default: v = edges[$urandom_range(0, 11)];
            endcase
            if ($urandom_range(0, 1) == 1) run_txn(v, $urandom_range(0, 3), $urandom_range(1, 2));
            else run_txn(v, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
